ss_burst_write_ctrl: RTL and testbench

- Parametrised successor of the single-channel RAM write sequencer.
- Takes a start request and an address window (start index, end index, stride, direction), then accepts a stream of data beats over a valid/ready handshake.
- Each accepted beat becomes one registered RAM write, stepping through the window. Completion reports done and error status.
- Sits between the data-producing datapath and a single-port RAM write port.

---
 rtl/ss_burst_write_ctrl_if.sv | 37 +++
 rtl/ss_burst_write_ctrl.sv | 137 +++++++++++++
 tb/tb_ss_burst_write_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ss_burst_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// ss_burst_write_ctrl_if: control, data-beat and RAM-write bundle for the burst write sequencer. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ss_burst_write_ctrl_if #(
  parameter int SIZE_ADDR = 6,
  parameter int SIZE_DATA = 8
);
  logic                 i_start;
  logic                 i_abort;
  logic [SIZE_ADDR-1:0] i_si_ram;
  logic [SIZE_ADDR-1:0] i_ei_ram;
  logic [SIZE_ADDR-1:0] i_stride;
  logic                 i_dir_down;
  logic                 i_valid;
  logic [SIZE_DATA-1:0] i_data;
  logic                 o_ready;
  logic                 o_we_ram;
  logic [SIZE_ADDR-1:0] o_addr_ram;
  logic [SIZE_DATA-1:0] o_data_ram;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;

  modport slave (
    input  i_start, i_abort, i_si_ram, i_ei_ram, i_stride, i_dir_down, i_valid, i_data,
    output o_ready, o_we_ram, o_addr_ram, o_data_ram, o_busy, o_done, o_err
  );

  modport master (
    output i_start, i_abort, i_si_ram, i_ei_ram, i_stride, i_dir_down, i_valid, i_data,
    input  o_ready, o_we_ram, o_addr_ram, o_data_ram, o_busy, o_done, o_err
  );
endinterface

`default_nettype wire

// File: rtl/ss_burst_write_ctrl.sv
// ---------------------------------------------------------------------------
// ss_burst_write_ctrl: windowed burst RAM write sequencer; optional SS_WR_BEAT_COUNT_EN adds o_beats_written. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ss_burst_write_ctrl #(
  parameter int SIZE_ADDR = 6,
  parameter int SIZE_DATA = 8,
  parameter int SIZE_CNT  = SIZE_ADDR + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  ss_burst_write_ctrl_if.slave    bus
`ifdef SS_WR_BEAT_COUNT_EN
  ,
  output logic [SIZE_CNT-1:0]     o_beats_written
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int unsigned MAX_BEATS = 1 << SIZE_ADDR;
  localparam logic [SIZE_CNT-1:0] CNT_FULL = SIZE_CNT'(MAX_BEATS);

  state_t               state_q;
  logic                 start_q;
  logic [SIZE_ADDR-1:0] ei_q;
  logic [SIZE_ADDR-1:0] stride_q;
  logic                 dir_q;
  logic [SIZE_ADDR-1:0] cur_addr_q;
  logic [SIZE_CNT-1:0]  cnt_q;
  logic                 we_q;
  logic [SIZE_ADDR-1:0] addr_q;
  logic [SIZE_DATA-1:0] data_q;
  logic                 done_q;
  logic                 err_q;

  logic                 start_edge;
  logic                 accept;
  logic [SIZE_ADDR-1:0] cur_addr_d;
  logic [SIZE_CNT-1:0]  cnt_d;

  assign start_edge = bus.i_start & ~start_q;
  assign accept     = bus.i_valid & (state_q == RUN);
  // Address arithmetic truncates to SIZE_ADDR, giving silent wrap in both directions.
  assign cur_addr_d = dir_q ? (cur_addr_q - stride_q) : (cur_addr_q + stride_q);
  assign cnt_d      = cnt_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      ei_q       <= '0;
      stride_q   <= '0;
      dir_q      <= 1'b0;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      start_q <= bus.i_start;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            ei_q       <= bus.i_ei_ram;
            stride_q   <= (bus.i_stride == '0) ? SIZE_ADDR'(1) : bus.i_stride;
            dir_q      <= bus.i_dir_down;
            cur_addr_q <= bus.i_si_ram;
            cnt_q      <= '0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            we_q       <= 1'b1;
            addr_q     <= cur_addr_q;
            data_q     <= bus.i_data;
            cur_addr_q <= cur_addr_d;
            cnt_q      <= cnt_d;
          end
          // Abort takes priority; a beat accepted alongside it is still written.
          if (bus.i_abort) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (accept && (cur_addr_q == ei_q)) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else if (accept && (cnt_d == CNT_FULL)) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_ready    = (state_q == RUN);
  assign bus.o_busy     = (state_q == RUN);
  assign bus.o_we_ram   = we_q;
  assign bus.o_addr_ram = addr_q;
  assign bus.o_data_ram = data_q;
  assign bus.o_done     = done_q;
  assign bus.o_err      = err_q;

`ifdef SS_WR_BEAT_COUNT_EN
  logic [SIZE_CNT-1:0] beats_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beats_q <= '0;
    end else if ((state_q == IDLE) && start_edge) begin
      beats_q <= '0;
    end else if (we_q) begin
      beats_q <= beats_q + 1'b1;
    end
  end

  assign o_beats_written = beats_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ss_burst_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ss_burst_write_ctrl: directed bursts with a queue-based write/done scoreboard. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ss_burst_write_ctrl;
  localparam int SA = 6;
  localparam int SD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ss_burst_write_ctrl_if #(.SIZE_ADDR(SA), .SIZE_DATA(SD)) bus ();

`ifdef SS_WR_BEAT_COUNT_EN
  logic [SA:0] beats;
`endif

  ss_burst_write_ctrl #(.SIZE_ADDR(SA), .SIZE_DATA(SD), .SIZE_CNT(SA + 1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef SS_WR_BEAT_COUNT_EN
    ,
    .o_beats_written (beats)
`endif
  );

  typedef struct packed {
    logic          we;
    logic [SA-1:0] addr;
    logic [SD-1:0] data;
    logic          done;
    logic          err;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push(input logic we, input logic [SA-1:0] a, input logic [SD-1:0] d,
                      input logic dn, input logic er);
    exp_t e;
    e.we = we; e.addr = a; e.data = d; e.done = dn; e.err = er;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every cycle showing a write, done or err must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_we_ram === 1'b1 || bus.o_done === 1'b1 || bus.o_err === 1'b1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: we=%b addr=%0d data=%0h done=%b err=%b, expected none",
                 bus.o_we_ram, bus.o_addr_ram, bus.o_data_ram, bus.o_done, bus.o_err);
      end else begin
        e = q.pop_front();
        if (bus.o_we_ram !== e.we || bus.o_done !== e.done || bus.o_err !== e.err ||
            (e.we && (bus.o_addr_ram !== e.addr || bus.o_data_ram !== e.data))) begin
          n_err++;
          $display("FAIL write: got we=%b addr=%0d data=%0h done=%b err=%b, expected we=%b addr=%0d data=%0h done=%b err=%b",
                   bus.o_we_ram, bus.o_addr_ram, bus.o_data_ram, bus.o_done, bus.o_err,
                   e.we, e.addr, e.data, e.done, e.err);
        end
      end
    end
  end

  task automatic start_burst(input logic [SA-1:0] si, input logic [SA-1:0] ei,
                             input logic [SA-1:0] st, input logic dn);
    bus.i_si_ram = si; bus.i_ei_ram = ei; bus.i_stride = st; bus.i_dir_down = dn;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(negedge clk);
    check("ready_run", 32'(bus.o_ready), 32'd1);
    check("busy_run", 32'(bus.o_busy), 32'd1);
  endtask

  task automatic beat(input logic v, input logic [SD-1:0] d, input logic ab);
    bus.i_valid = v; bus.i_data = d; bus.i_abort = ab;
    @(posedge clk); #1;
  endtask

  task automatic finish_burst();
    bus.i_valid = 1'b0; bus.i_abort = 1'b0;
    @(negedge clk);
    check("ready_fin", 32'(bus.o_ready), 32'd0);
    check("busy_fin", 32'(bus.o_busy), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(bus.o_we_ram),   32'd0);
    check({tag, "_addr"},  32'(bus.o_addr_ram), 32'd0);
    check({tag, "_data"},  32'(bus.o_data_ram), 32'd0);
    check({tag, "_done"},  32'(bus.o_done),     32'd0);
    check({tag, "_err"},   32'(bus.o_err),      32'd0);
    check({tag, "_busy"},  32'(bus.o_busy),     32'd0);
    check({tag, "_ready"}, 32'(bus.o_ready),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_valid = 1'b0; bus.i_data = '0;
    bus.i_si_ram = '0; bus.i_ei_ram = '0; bus.i_stride = '0; bus.i_dir_down = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic up burst 2..5
    push(1, 6'd2, 8'hA0, 0, 0); push(1, 6'd3, 8'hA1, 0, 0);
    push(1, 6'd4, 8'hA2, 0, 0); push(1, 6'd5, 8'hA3, 1, 0);
    start_burst(6'd2, 6'd5, 6'd1, 1'b0);
    beat(1, 8'hA0, 0); beat(1, 8'hA1, 0); beat(1, 8'hA2, 0); beat(1, 8'hA3, 0);
    finish_burst();
`ifdef SS_WR_BEAT_COUNT_EN
    check("beats_written", 32'(beats), 32'd4);
`endif

    // Wrap-around 62..1
    push(1, 6'd62, 8'hB0, 0, 0); push(1, 6'd63, 8'hB1, 0, 0);
    push(1, 6'd0,  8'hB2, 0, 0); push(1, 6'd1,  8'hB3, 1, 0);
    start_burst(6'd62, 6'd1, 6'd1, 1'b0);
    beat(1, 8'hB0, 0); beat(1, 8'hB1, 0); beat(1, 8'hB2, 0); beat(1, 8'hB3, 0);
    finish_burst();

    // Down by 2 with valid gaps
    push(1, 6'd10, 8'hD0, 0, 0); push(1, 6'd8, 8'hD1, 0, 0);
    push(1, 6'd6,  8'hD2, 0, 0); push(1, 6'd4, 8'hD3, 1, 0);
    start_burst(6'd10, 6'd4, 6'd2, 1'b1);
    beat(1, 8'hD0, 0); beat(0, 8'hEE, 0); beat(1, 8'hD1, 0); beat(0, 8'hEE, 0);
    beat(1, 8'hD2, 0); beat(0, 8'hEE, 0); beat(1, 8'hD3, 0);
    finish_burst();

    // Overrun: stride 2 from 0 never lands on 3
    for (int i = 0; i < 64; i++)
      push(1, 6'((2 * i) % 64), 8'(i), (i == 63), (i == 63));
    start_burst(6'd0, 6'd3, 6'd2, 1'b0);
    for (int i = 0; i < 64; i++) beat(1, 8'(i), 0);
    finish_burst();

    // Stride 0 behaves as 1
    for (int i = 0; i < 4; i++) push(1, 6'(i), 8'(8'h60 + i), (i == 3), 0);
    start_burst(6'd0, 6'd3, 6'd0, 1'b0);
    for (int i = 0; i < 4; i++) beat(1, 8'(8'h60 + i), 0);
    finish_burst();

    // Abort with the second accept, then a fresh burst
    push(1, 6'd20, 8'h11, 0, 0); push(1, 6'd21, 8'h22, 1, 1);
    start_burst(6'd20, 6'd24, 6'd1, 1'b0);
    beat(1, 8'h11, 0); beat(1, 8'h22, 1);
    finish_burst();
    push(1, 6'd40, 8'h33, 0, 0); push(1, 6'd41, 8'h44, 1, 0);
    start_burst(6'd40, 6'd41, 6'd1, 1'b0);
    beat(1, 8'h33, 0); beat(1, 8'h44, 0);
    finish_burst();

    // Abort with no beat accepted
    push(0, 6'd0, 8'h00, 1, 1);
    start_burst(6'd7, 6'd9, 6'd1, 1'b0);
    beat(0, 8'h00, 1);
    finish_burst();

    // Reset mid-burst with i_start held high through reset
    push(1, 6'd0, 8'h51, 0, 0); push(1, 6'd1, 8'h52, 0, 0);
    start_burst(6'd0, 6'd10, 6'd1, 1'b0);
    beat(1, 8'h51, 0); beat(1, 8'h52, 0);
    bus.i_si_ram = 6'd50; bus.i_ei_ram = 6'd51; bus.i_stride = 6'd1; bus.i_dir_down = 1'b0;
    bus.i_start = 1'b1; bus.i_valid = 1'b1; bus.i_data = 8'h55;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.i_valid = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(negedge clk);
    check("busy_after_reset", 32'(bus.o_busy), 32'd1);
    push(1, 6'd50, 8'hC0, 0, 0); push(1, 6'd51, 8'hC1, 1, 0);
    bus.i_start = 1'b1;
    beat(1, 8'hC0, 0);
    bus.i_start = 1'b0;
    beat(1, 8'hC1, 0);
    finish_burst();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("no_extra_burst", 32'(bus.o_busy), 32'd0);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
